// File: rtl/edge_delay_meter.sv
`default_nettype none
// ============================================================================
// Module   : edge_delay_meter
// Purpose  : Measures the round-trip delay of an external delay element.
//            A start request raises launch; the number of clk cycles until
//            the rising edge of echo is seen is captured into delay_cnt.
//            If no edge arrives within TIMEOUT cycles of waiting, the
//            measurement aborts and delay_cnt is loaded with all ones.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W      width of the delay counter and of delay_cnt
//   TIMEOUT    WAIT cycles before abort, legal range 1 .. 2^CNT_W-2
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   start      measurement request, sampled every cycle
//   echo       signal returned from the delay element under test
//   launch     registered drive into the delay element under test
//   busy       high whenever the FSM is not IDLE
//   done       one-cycle pulse when a delay is captured
//   timeout    one-cycle pulse when a measurement aborts
//   delay_cnt  last measured delay in clk cycles
// Build option
//   EDGE_DELAY_SYNC_EN  when defined, echo passes through a two-flop
//                       synchroniser, adding 2 cycles to every captured count
// ============================================================================
module edge_delay_meter #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             echo,
  output logic             launch,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] delay_cnt
);

  // Last counter value examined in WAIT before the abort fires.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] delay_nx;
  logic             launch_nx;
  logic             done_nx;
  logic             timeout_nx;

  logic             echo_s;
  logic             echo_p;
  logic             edge_seen;

  // --------------------------------------------------------------------------
  // Echo sampling
  // --------------------------------------------------------------------------
`ifdef EDGE_DELAY_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], echo};
    end
  end

  assign echo_s = sync_q[1];
`else
  // Echo is assumed already synchronous to clk; used as-is.
  assign echo_s = echo;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_p <= 1'b0;
    end else begin
      echo_p <= echo_s;
    end
  end

  assign edge_seen = echo_s & ~echo_p;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      delay_cnt <= '0;
      launch    <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      delay_cnt <= delay_nx;
      launch    <= launch_nx;
      done      <= done_nx;
      timeout   <= timeout_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    delay_nx   = delay_cnt;
    launch_nx  = launch;
    done_nx    = 1'b0;
    timeout_nx = 1'b0;

    case (state)
      IDLE: begin
        launch_nx = 1'b0;
        // A start while echo is still high would make the first edge
        // ambiguous, so it is dropped rather than queued.
        if (start && !echo_s) begin
          state_nx  = WAIT;
          cnt_nx    = '0;
          launch_nx = 1'b1;
        end
      end

      WAIT: begin
        // Edge takes priority over the abort when both land together.
        if (edge_seen) begin
          delay_nx  = cnt;
          done_nx   = 1'b1;
          launch_nx = 1'b0;
          state_nx  = DRAIN;
        end else if (cnt == CNT_LAST) begin
          delay_nx   = '1;
          timeout_nx = 1'b1;
          launch_nx  = 1'b0;
          state_nx   = DRAIN;
        end else begin
          // Bounded by CNT_LAST, so the counter cannot wrap.
          cnt_nx = cnt + 1'b1;
        end
      end

      DRAIN: begin
        // Wait for echo to fall so the next measurement starts from low.
        launch_nx = 1'b0;
        if (!echo_s) begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx  = IDLE;
        launch_nx = 1'b0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_edge_delay_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_delay_meter
// Purpose  : Self-checking bench for edge_delay_meter. Directed measurements
//            push their expected result (kind, count, arrival cycle) into a
//            queue; an independent monitor pops an entry whenever done or
//            timeout pulses and compares it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_delay_meter;

  localparam int CNT_W = 8;
  localparam int TO    = 10;
`ifdef EDGE_DELAY_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic             echo;
  logic             launch;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] delay_cnt;

  edge_delay_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .echo      (echo),
    .launch    (launch),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .delay_cnt (delay_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Delay element model: 0 = echo tied low, 1 = tied high,
  // 2 = launch delayed by ndly cycles (ndly=0 is a straight loopback).
  int          emode = 2;
  int          ndly  = 0;
  logic [15:0] hist  = '0;
  always @(posedge clk) hist <= {hist[14:0], launch};
  always_comb begin
    if (emode == 0)      echo = 1'b0;
    else if (emode == 1) echo = 1'b1;
    else if (ndly == 0)  echo = launch;
    else                 echo = hist[ndly-1];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic is_to;
    int   d;
    int   at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Monitor: every done/timeout pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (done || timeout)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, done, timeout}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_done",    int'(done),      int'(!mon_e.is_to));
        chk("pulse_timeout", int'(timeout),   int'(mon_e.is_to));
        chk("delay_cnt",     int'(delay_cnt), mon_e.d);
        chk("pulse_cycle",   cyc,             mon_e.at);
      end
    end
  end

  // One measurement: lat = cycles from the start-sampling edge to the pulse,
  // drain = cycles from the pulse to busy falling, restart = cycles after
  // launch to pulse start again (0 = no extra pulse).
  task automatic run_meas(input int m, input int n, input bit to, input int d,
                          input int lat, input int drain, input int restart);
    int c0;
    int w;
    @(negedge clk);
    emode = m;
    ndly  = n;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    exp_q.push_back('{is_to: to, d: d, at: c0 + lat});
    chk("busy_after_start",   int'(busy),   1);
    chk("launch_after_start", int'(launch), 1);
    if (restart > 0) begin
      repeat (restart) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      chk("pulse_missing", exp_q.size(), 0);
      exp_q.delete();
    end
    w = 0;
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("busy_fall_cycle", cyc, c0 + lat + drain);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_launch",    int'(launch),    0);
    chk("rst_busy",      int'(busy),      0);
    chk("rst_done",      int'(done),      0);
    chk("rst_timeout",   int'(timeout),   0);
    chk("rst_delay_cnt", int'(delay_cnt), 0);
    rst = 1'b0;

    // Loopback: edge seen on the first WAIT cycle.
    run_meas(2, 0, 1'b0, S, S + 1, 1 + S, 0);
    // Five-cycle delay element, with a stray start during WAIT.
    run_meas(2, 5, 1'b0, 5 + S, 6 + S, 6 + S, 2);
    // No echo at all: abort TO cycles after entering WAIT.
    run_meas(0, 0, 1'b1, 255, TO, 1, 0);
    // Edge exactly on the last WAIT cycle: capture wins over abort.
    run_meas(2, TO - 1 - S, 1'b0, TO - 1, TO, TO, 0);

    // Echo stuck high: start must be ignored.
    @(negedge clk);
    emode = 1;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("echo_high_busy",   int'(busy),   0);
      chk("echo_high_launch", int'(launch), 0);
      @(negedge clk);
    end
    emode = 0;
    repeat (4) @(negedge clk);

    // Reset in the middle of WAIT aborts silently.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy_before", int'(busy), 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_launch",    int'(launch),    0);
    chk("abort_delay_cnt", int'(delay_cnt), 0);
    chk("abort_busy",      int'(busy),      0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_idle", int'(busy), 0);

    // Measurement after the abort behaves normally.
    run_meas(2, 0, 1'b0, S, S + 1, 1 + S, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edge_delay_meter.md
EDGE_DELAY_METER -- requirements
Module: edge_delay_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, the width of the delay counter and result.
REQ-002 The block SHALL have parameter TIMEOUT, default 200, the WAIT cycles before abort; legal range 1 to 2^CNT_W-2.
REQ-003 Port clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port start  input  1  measurement request, sampled each cycle.
REQ-006 Port echo  input  1  signal returned from the delay element under test.
REQ-007 Port launch  output  1  registered drive into the delay element under test.
REQ-008 Port busy  output  1  high whenever state is not IDLE.
REQ-009 Port done  output  1  one-cycle pulse when a delay is captured.
REQ-010 Port timeout  output  1  one-cycle pulse when a measurement aborts.
REQ-011 Port delay_cnt  output  CNT_W  last measured delay in clk cycles.

Function
REQ-012 The FSM SHALL have states IDLE, WAIT, DRAIN, all registered.
REQ-013 echo_s SHALL be the sampled echo (see REQ-027/028); edge SHALL be echo_s high while its previous-cycle copy echo_p is low.
REQ-014 In IDLE, start=1 with echo_s=0 SHALL move to WAIT next cycle, clear cnt to 0 and set launch=1.
REQ-015 In IDLE, start=1 with echo_s=1 SHALL be ignored; the block stays in IDLE.
REQ-016 start SHALL be ignored in WAIT and DRAIN; no queuing.
REQ-017 In WAIT, edge=1 SHALL capture cnt into delay_cnt, pulse done for one cycle, clear launch and go to DRAIN.
REQ-018 In WAIT, edge=0 with cnt=TIMEOUT-1 SHALL load delay_cnt with all ones, pulse timeout for one cycle, clear launch and go to DRAIN.
REQ-019 In WAIT, in all other cases cnt SHALL increment by one; cnt SHALL never wrap.
REQ-020 If edge and the timeout condition occur in the same cycle, edge SHALL win: done pulses, timeout stays 0.
REQ-021 In DRAIN, launch SHALL be 0, and the block SHALL return to IDLE on the first cycle with echo_s=0.
REQ-022 delay_cnt SHALL hold its value until the next capture or timeout.
REQ-023 done and timeout SHALL never be high in the same cycle.
REQ-024 Meaning of a captured count: number of cycles between the first cycle launch is high and the cycle edge is seen.

Reset
REQ-025 While rst=1, the block SHALL be in IDLE with launch=0, busy=0, done=0, timeout=0, delay_cnt=0, cnt=0.
REQ-026 While rst=1, all synchroniser and echo_p flops SHALL be 0; reset mid-measurement SHALL abort without a done or timeout pulse.

Configuration
REQ-027 With macro EDGE_DELAY_SYNC_EN defined, echo SHALL pass through a two-flop synchroniser before echo_s, adding exactly 2 cycles to every captured count.
REQ-028 Without EDGE_DELAY_SYNC_EN, echo_s SHALL equal echo directly (echo_p remains a register), adding 0 cycles.

Verification
REQ-029 Loopback echo=launch, start pulse after reset -> done after one WAIT cycle, delay_cnt=0 (sync off) or 2 (sync on).
REQ-030 echo = launch delayed externally by 5 cycles -> delay_cnt=5 (sync off) or 7 (sync on), then busy falls once echo returns low.
REQ-031 echo tied 0, TIMEOUT=10 -> timeout pulse 10 cycles after entering WAIT, delay_cnt=8'hFF, done never asserted.
REQ-032 echo tied 1, start pulsed -> no transition, busy stays 0; start pulsed during WAIT -> no effect on the running measurement.
REQ-033 rst asserted for one cycle in the middle of WAIT -> launch=0, delay_cnt=0 immediately, no done or timeout pulse; the next start measures correctly.
REQ-034 Edge arriving on cycle cnt=TIMEOUT-1 -> done=1, timeout=0, delay_cnt=TIMEOUT-1.
